// File: rtl/ethernet_sniffer_if.sv
// Stream-in / capture-memory-out bundle of the ethernet_sniffer.
// master = packet source and capture memory side, slave = the sniffer.
interface ethernet_sniffer_if;
  logic [31:0] data_in;
  logic        sop;
  logic        eop;
  logic        valid;
  logic        error;
  logic        empty;
  logic        ready;
  logic        rdempty;
  logic        rdreq;
  logic [31:0] data_out;
  logic        wr_en;
  logic        addr_as;
  logic [31:0] addr_out;

  modport master (
    output data_in, sop, eop, valid, error, empty, ready, rdempty,
    input  rdreq, data_out, wr_en, addr_as, addr_out
  );

  modport slave (
    input  data_in, sop, eop, valid, error, empty, ready, rdempty,
    output rdreq, data_out, wr_en, addr_as, addr_out
  );
endinterface

// File: rtl/ethernet_sniffer.sv
// 6-stage packet inspection pipeline: header/string match flags a word,
// and a capture FSM writes the rest of that packet to memory.

module ethernet_sniffer_strlane #(
  parameter int OFF = 0
) (
  input  logic [0:19][7:0] win,
  input  logic [0:16][7:0] str,
  input  logic [0:16]      str_use,
  output logic             hit
);
  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < 17; i++)
      if (str_use[i] && (win[OFF+i] != str[i])) hit = 1'b0;
  end
endmodule

module ethernet_sniffer (
  input  logic             clk,
  input  logic             rst,
  ethernet_sniffer_if.slave bus,
  input  logic [47:0]      flagged_mac,
  input  logic [31:0]      flagged_ip,
  input  logic [15:0]      flagged_port,
  input  logic [0:16][7:0] flagged_string
);
  localparam int STAGES    = 6;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic        error;
    logic        empty;
    logic        hit;
  } sb_t;

  typedef enum logic {IDLE, CAPTURE} state_t;

  sb_t               st [1:STAGES];
  logic [STAGES:1]   vld_pipe;
  logic [3:0]        idx;
  logic              ipv4_ok;
  logic              hdr_hit;
  logic              str_hit;
  logic [0:16]       str_use;
  logic [0:19][7:0]  win;
  logic [NUM_LANES-1:0] lane_hit;
  state_t            state, state_nx;
  logic              sel, first, term, s5_hit;
  logic [31:0]       ptr;
  logic [31:0]       s1, s2;
  logic              mac_en, ip_en, port_en;

  assign s1      = st[1].data;
  assign s2      = st[2].data;
  assign mac_en  = |flagged_mac;
  assign ip_en   = |flagged_ip;
  assign port_en = |flagged_port;

  // idx tracks the index of the newest valid word, i.e. the word in S1
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 4'd0;
      ipv4_ok <= 1'b0;
    end else begin
      if (bus.valid) idx <= bus.sop ? 4'd0 : ((idx == 4'd15) ? idx : idx + 4'd1);
      if (bus.valid && bus.sop)
        ipv4_ok <= 1'b0;
      else if (vld_pipe[1] && idx == 4'd3)
        ipv4_ok <= (s1[31:16] == 16'h0800) && (s1[15:12] == 4'd4) && (s1[11:8] == 4'd5);
    end
  end

  always_comb begin
    hdr_hit = 1'b0;
    if (vld_pipe[1]) begin
      case (idx)
        4'd1: hdr_hit = mac_en && ({s2, s1[31:16]} == flagged_mac);
        4'd2: hdr_hit = mac_en && ({s2[15:0], s1} == flagged_mac);
        4'd7: hdr_hit = ipv4_ok && ip_en && ({s2[15:0], s1[31:16]} == flagged_ip);
        4'd8: hdr_hit = ipv4_ok && ((ip_en && ({s2[15:0], s1[31:16]} == flagged_ip)) ||
                                    (port_en && (s1[15:0] == flagged_port)));
        4'd9: hdr_hit = ipv4_ok && port_en && (s1[31:16] == flagged_port);
        default: hdr_hit = 1'b0;
      endcase
    end
  end

  // string length = run of leading non-zero bytes
  always_comb begin
    str_use    = '0;
    str_use[0] = |flagged_string[0];
    for (int i = 1; i < 17; i++)
      str_use[i] = str_use[i-1] && (|flagged_string[i]);
  end

  assign win = {st[5].data, st[4].data, st[3].data, st[2].data, st[1].data};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    ethernet_sniffer_strlane #(.OFF(g)) u_lane (
      .win     (win),
      .str     (flagged_string),
      .str_use (str_use),
      .hit     (lane_hit[g])
    );
  end

  assign str_hit = vld_pipe[5] && str_use[0] && (|lane_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= STAGES; i++) st[i] <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid};
      st[1]    <= '{data: bus.data_in, sop: bus.sop, eop: bus.eop,
                    error: bus.error, empty: bus.empty, hit: 1'b0};
      st[2]     <= st[1];
      st[2].hit <= st[1].hit | hdr_hit;
      st[3]     <= st[2];
      st[4]     <= st[3];
      st[5]     <= st[4];
      st[6]     <= st[5];
      st[6].hit <= st[5].hit | str_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sel      = 1'b0;
    first    = 1'b0;
    term     = st[5].eop | st[5].error;
    s5_hit   = st[5].hit | str_hit;
    case (state)
      IDLE: if (vld_pipe[5] && s5_hit) begin
        sel   = 1'b1;
        first = 1'b1;
        if (!term) state_nx = CAPTURE;
      end
      CAPTURE: if (vld_pipe[5]) begin
        sel = 1'b1;
        if (term) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // a selected word seen with ready low is dropped without consuming an address
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en    <= 1'b0;
      bus.addr_as  <= 1'b0;
      bus.addr_out <= 32'd0;
      bus.rdreq    <= 1'b0;
      ptr          <= 32'd0;
    end else begin
      bus.wr_en    <= sel & bus.ready;
      bus.addr_as  <= first & bus.ready;
      bus.addr_out <= ptr;
      bus.rdreq    <= ~bus.rdempty;
      if (sel && bus.ready) ptr <= ptr + 32'd4;
    end
  end

  assign bus.data_out = st[6].data;

  logic unused_ok;
  assign unused_ok = ^{st[6].sop, st[6].eop, st[6].error, st[6].empty, st[6].hit,
                       vld_pipe[6]};
endmodule

// File: tb/tb_ethernet_sniffer.sv
// Directed bench for ethernet_sniffer: expected stream words and memory
// writes are queued at stimulus time and checked by an independent monitor.
module tb_ethernet_sniffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ethernet_sniffer_if bus();
  logic [47:0]      flagged_mac;
  logic [31:0]      flagged_ip;
  logic [15:0]      flagged_port;
  logic [0:16][7:0] flagged_string;

  ethernet_sniffer dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .flagged_mac    (flagged_mac),
    .flagged_ip     (flagged_ip),
    .flagged_port   (flagged_port),
    .flagged_string (flagged_string)
  );

  typedef struct {int due; logic [31:0] d;} sx_t;
  typedef struct {logic [31:0] d; logic [31:0] a; logic first;} wx_t;

  sx_t sq[$];
  wx_t wq[$];
  int tests = 0, fails = 0, cyc = 0, wr_seen = 0;
  logic [31:0] pkt [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    sx_t se;
    wx_t we;
    while (sq.size() > 0 && sq[0].due <= cyc) begin
      se = sq.pop_front();
      check("stream_data", {32'd0, bus.data_out}, {32'd0, se.d});
    end
    if (bus.wr_en) begin
      wr_seen++;
      if (wq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: wr_en=1 data %h addr %h, required no write",
                 bus.data_out, bus.addr_out);
      end else begin
        we = wq.pop_front();
        check("wr_data_addr", {bus.data_out, bus.addr_out}, {we.d, we.a});
        check("wr_addr_as", {63'd0, bus.addr_as}, {63'd0, we.first});
      end
    end else if (bus.addr_as) begin
      tests++;
      fails++;
      $display("FAIL as_without_wr: addr_as=1 with wr_en=0, required 0");
    end
  end

  task automatic expw(input logic [31:0] d, input logic [31:0] a, input logic f);
    wq.push_back('{d: d, a: a, first: f});
  endtask

  // word s is in S5 when ready is driven in slot s+5, so drops lag by 5 slots
  task automatic send(input int n, input int drop_lo);
    for (int s = 0; s < n + 12; s++) begin
      @(posedge clk); #1;
      if (s < n) begin
        bus.data_in = pkt[s];
        bus.valid   = 1'b1;
        bus.sop     = (s == 0);
        bus.eop     = (s == n - 1);
        sq.push_back('{due: cyc + 6, d: pkt[s]});
      end else begin
        bus.data_in = 32'd0;
        bus.valid   = 1'b0;
        bus.sop     = 1'b0;
        bus.eop     = 1'b0;
      end
      bus.ready = !(drop_lo >= 0 && (s - 5) >= drop_lo && (s - 5) < drop_lo + 2);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_seen = 0;
  endtask

  task automatic load_a;  // Ethernet + IPv4 + TCP, dst port 0x0050
    logic [31:0] a [0:15];
    a = '{32'h641225eb, 32'h1080809b, 32'h4c3a5e71, 32'h08004500,
          32'h00281c46, 32'h40004006, 32'hb1e6c0a8, 32'h0001c0a8,
          32'h00c7d431, 32'h00501234, 32'h56789abc, 32'h00000000,
          32'h50027210, 32'habcd0000, 32'h11223344, 32'h55667788};
    for (int i = 0; i < 16; i++) pkt[i] = a[i];
  endtask

  task automatic load_b;  // non-IPv4 header + "GET / HTTP/1.1\r\nHost: www.purdue.edu\r\n\r\n"
    logic [31:0] b [0:13];
    b = '{32'h00112233, 32'h44550066, 32'h778899aa, 32'h86dd0000,
          32'h47455420, 32'h2f204854, 32'h54502f31, 32'h2e310d0a,
          32'h486f7374, 32'h3a207777, 32'h772e7075, 32'h72647565,
          32'h2e656475, 32'h0d0a0d0a};
    for (int i = 0; i < 14; i++) pkt[i] = b[i];
  endtask

  initial begin
    flagged_mac    = '0;
    flagged_ip     = '0;
    flagged_port   = '0;
    flagged_string = '0;
    bus.data_in = 32'hdeadbeef;
    bus.valid   = 1'b1;
    bus.sop     = 1'b1;
    bus.eop     = 1'b0;
    bus.error   = 1'b0;
    bus.empty   = 1'b0;
    bus.ready   = 1'b1;
    bus.rdempty = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data_out", {32'd0, bus.data_out}, 64'd0);
    check("rst_addr_out", {32'd0, bus.addr_out}, 64'd0);
    check("rst_wr_en",    {63'd0, bus.wr_en},    64'd0);
    check("rst_addr_as",  {63'd0, bus.addr_as},  64'd0);
    check("rst_rdreq",    {63'd0, bus.rdreq},    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.data_in = 32'd0;
    bus.valid   = 1'b0;
    bus.sop     = 1'b0;
    @(negedge clk);
    check("rdreq_before_edge", {63'd0, bus.rdreq}, 64'd0);
    @(negedge clk);
    check("rdreq_after_release", {63'd0, bus.rdreq}, 64'd1);

    // latency: five words, no flags
    pkt[0] = 32'h01020304; pkt[1] = 32'h11121314; pkt[2] = 32'ha5a5a5a5;
    pkt[3] = 32'h5a5a5a5a; pkt[4] = 32'hcafef00d;
    wr_seen = 0;
    send(5, -1);
    check("latency_wr_count", 64'(wr_seen), 64'd0);

    // string capture starts at word holding ": ww"
    do_reset();
    flagged_string = {"www.purdue.edu", 24'h0};
    load_b();
    expw(32'h3a207777, 32'd0,  1'b1);
    expw(32'h772e7075, 32'd4,  1'b0);
    expw(32'h72647565, 32'd8,  1'b0);
    expw(32'h2e656475, 32'd12, 1'b0);
    expw(32'h0d0a0d0a, 32'd16, 1'b0);
    send(14, -1);
    check("string_wr_count", 64'(wr_seen), 64'd5);
    flagged_string = '0;

    // MAC capture starts at index-1 word
    do_reset();
    flagged_mac = 48'h641225eb1080;
    load_a();
    for (int i = 1; i < 16; i++) expw(pkt[i], 32'((i - 1) * 4), i == 1);
    send(16, -1);
    check("mac_wr_count", 64'(wr_seen), 64'd15);
    flagged_mac = '0;

    // port capture at index 9, words 11 and 12 dropped by ready
    do_reset();
    flagged_port = 16'h0050;
    load_a();
    expw(32'h00501234, 32'd0,  1'b1);
    expw(32'h56789abc, 32'd4,  1'b0);
    expw(32'habcd0000, 32'd8,  1'b0);
    expw(32'h11223344, 32'd12, 1'b0);
    expw(32'h55667788, 32'd16, 1'b0);
    send(16, 11);
    check("port_wr_count", 64'(wr_seen), 64'd5);
    flagged_port = '0;

    // all flags disabled: stream only
    do_reset();
    load_a();
    send(16, -1);
    load_b();
    send(14, -1);
    check("disabled_wr_count", 64'(wr_seen), 64'd0);

    check("wr_queue_drained",     64'(wq.size()), 64'd0);
    check("stream_queue_drained", 64'(sq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
